// File: rtl/mem_stage_bus.sv
// bexkat1 memory stage: registered bus cycle FSM, big-endian lane steering, bus-error and ack-timeout faults.
// Optional misalignment trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage_bus #(
   parameter int          ADDR_W      = 32,
   parameter int          TIMEOUT_CYC = 16,
   parameter logic [31:0] FAULT_VEC   = 32'h0000_0000,
   parameter logic [31:0] ALIGN_VEC   = 32'h0000_0008
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              stall_i,
   output logic              stall_o,
   input  logic              halt_i,
   output logic              halt_o,
   input  logic [63:0]       ir_i,
   output logic [63:0]       ir_o,
   input  logic [31:0]       result_i,
   output logic [31:0]       result_o,
   input  logic [31:0]       reg_data1_i,
   input  logic [1:0]        reg_write_i,
   output logic [1:0]        reg_write_o,
   input  logic [31:0]       pc_i,
   output logic [31:0]       pc_o,
   input  logic              pc_set_i,
   output logic              pc_set_o,
   input  logic              exc_i,
   output logic              exc_o,
   output logic [1:0]        fault_o,
   output logic [ADDR_W-1:0] bus_adr,
   output logic              bus_cyc,
   output logic              bus_we,
   output logic [3:0]        bus_sel,
   output logic [31:0]       bus_out,
   input  logic [31:0]       bus_in,
   input  logic              bus_ack,
   input  logic              bus_err
);

   localparam logic [3:0] T_LOAD   = 4'hc;
   localparam logic [3:0] T_STORE  = 4'hd;
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

   localparam logic [1:0] SZ_LONG = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_BYTE = 2'd2;

   localparam logic [1:0] F_NONE  = 2'd0;
   localparam logic [1:0] F_BUS   = 2'd1;
   localparam logic [1:0] F_TMO   = 2'd2;
   localparam logic [1:0] F_ALIGN = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Size code 3 and exception fetches behave as long accesses.
   function automatic logic [1:0] norm_size(input logic [1:0] sz, input logic exc);
      logic [1:0] r;
      if (exc) begin
         r = SZ_LONG;
      end else begin
         case (sz)
            2'd1:    r = SZ_HALF;
            2'd2:    r = SZ_BYTE;
            default: r = SZ_LONG;
         endcase
      end
      return r;
   endfunction

   function automatic logic [3:0] lane_sel(input logic [1:0] sz, input logic [1:0] adr);
      logic [3:0] r;
      case (sz)
         SZ_HALF: r = adr[1] ? 4'b0011 : 4'b1100;
         SZ_BYTE: begin
            case (adr)
               2'd0:    r = 4'b1000;
               2'd1:    r = 4'b0100;
               2'd2:    r = 4'b0010;
               default: r = 4'b0001;
            endcase
         end
         default: r = 4'b1111;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
      logic [31:0] r;
      case (sz)
         SZ_HALF: r = {d[15:0], d[15:0]};
         SZ_BYTE: r = {4{d[7:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic [1:0] adr,
                                                input logic [31:0] d);
      logic [31:0] r;
      case (sz)
         SZ_HALF: r = adr[1] ? {16'h0000, d[15:0]} : {16'h0000, d[31:16]};
         SZ_BYTE: begin
            case (adr)
               2'd0:    r = {24'h000000, d[31:24]};
               2'd1:    r = {24'h000000, d[23:16]};
               2'd2:    r = {24'h000000, d[15:8]};
               default: r = {24'h000000, d[7:0]};
            endcase
         end
         default: r = d;
      endcase
      return r;
   endfunction

   state_t      state_r;
   logic [7:0]  timer_r;
   logic [1:0]  size_r;
   logic [1:0]  adr_lo_r;
   logic        store_r;
   logic        exc_req_r;
   logic [31:0] data_r;
   logic [1:0]  fault_r;

   logic        mem_op_s;
   logic        store_s;
   logic [1:0]  size_s;
   logic        misalign_s;

   // Decode the incoming instruction into access attributes.
   always_comb begin
      mem_op_s = (ir_i[31:28] == T_LOAD) || (ir_i[31:28] == T_STORE) || exc_i;
      store_s  = (ir_i[31:28] == T_STORE) && !exc_i;
      size_s   = norm_size(ir_i[25:24], exc_i);
`ifdef MEM_ALIGN_CHECK_EN
      case (size_s)
         SZ_HALF: misalign_s = result_i[0];
         SZ_BYTE: misalign_s = 1'b0;
         default: misalign_s = (result_i[1:0] != 2'b00);
      endcase
`else
      misalign_s = 1'b0;
`endif
   end

   // Upstream stall: a fresh mem op stalls at once; HOLD only releases with downstream.
   always_comb begin
      stall_o = 1'b0;
      case (state_r)
         ST_IDLE: stall_o = mem_op_s;
         ST_BUS:  stall_o = 1'b1;
         ST_HOLD: stall_o = stall_i;
         default: stall_o = 1'b0;
      endcase
   end

   // Stage FSM, bus master registers and pipeline output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= ST_IDLE;
         timer_r     <= 8'd0;
         size_r      <= 2'd0;
         adr_lo_r    <= 2'd0;
         store_r     <= 1'b0;
         exc_req_r   <= 1'b0;
         data_r      <= 32'h0000_0000;
         fault_r     <= F_NONE;
         halt_o      <= 1'b0;
         ir_o        <= 64'h0;
         result_o    <= 32'h0000_0000;
         reg_write_o <= 2'b00;
         pc_o        <= 32'h0000_0000;
         pc_set_o    <= 1'b0;
         exc_o       <= 1'b0;
         fault_o     <= F_NONE;
         bus_adr     <= '0;
         bus_cyc     <= 1'b0;
         bus_we      <= 1'b0;
         bus_sel     <= 4'b0000;
         bus_out     <= 32'h0000_0000;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (stall_i) begin
                  state_r <= ST_IDLE;
               end else if (mem_op_s) begin
                  size_r    <= size_s;
                  adr_lo_r  <= result_i[1:0];
                  store_r   <= store_s;
                  exc_req_r <= exc_i;
                  timer_r   <= 8'd0;
                  if (misalign_s) begin
                     fault_r <= F_ALIGN;
                     state_r <= ST_HOLD;
                  end else begin
                     fault_r <= F_NONE;
                     bus_adr <= result_i[ADDR_W-1:0];
                     bus_we  <= store_s;
                     bus_sel <= lane_sel(size_s, result_i[1:0]);
                     bus_out <= store_s ? store_data(size_s, reg_data1_i) : 32'h0000_0000;
                     bus_cyc <= 1'b1;
                     state_r <= ST_BUS;
                  end
               end else begin
                  halt_o      <= halt_i;
                  ir_o        <= ir_i;
                  result_o    <= result_i;
                  reg_write_o <= reg_write_i;
                  pc_o        <= pc_i;
                  pc_set_o    <= pc_set_i;
                  exc_o       <= 1'b0;
                  fault_o     <= F_NONE;
               end
            end
            ST_BUS: begin
               timer_r <= timer_r + 8'd1;
               if (bus_err) begin
                  fault_r <= F_BUS;
                  bus_cyc <= 1'b0;
                  bus_we  <= 1'b0;
                  state_r <= ST_HOLD;
               end else if (bus_ack) begin
                  data_r  <= load_extract(size_r, adr_lo_r, bus_in);
                  bus_cyc <= 1'b0;
                  bus_we  <= 1'b0;
                  state_r <= ST_HOLD;
               end else if (timer_r == TMO_LAST) begin
                  fault_r <= F_TMO;
                  bus_cyc <= 1'b0;
                  bus_we  <= 1'b0;
                  state_r <= ST_HOLD;
               end else begin
                  state_r <= ST_BUS;
               end
            end
            ST_HOLD: begin
               if (stall_i) begin
                  state_r <= ST_HOLD;
               end else begin
                  halt_o  <= halt_i;
                  ir_o    <= ir_i;
                  fault_o <= fault_r;
                  state_r <= ST_IDLE;
                  if (fault_r != F_NONE) begin
                     result_o    <= result_i;
                     reg_write_o <= 2'b00;
                     pc_o        <= (fault_r == F_ALIGN) ? ALIGN_VEC : FAULT_VEC;
                     pc_set_o    <= 1'b1;
                     exc_o       <= 1'b1;
                  end else if (exc_req_r) begin
                     result_o    <= result_i;
                     reg_write_o <= reg_write_i;
                     pc_o        <= data_r;
                     pc_set_o    <= 1'b1;
                     exc_o       <= 1'b1;
                  end else begin
                     result_o    <= store_r ? result_i : data_r;
                     reg_write_o <= reg_write_i;
                     pc_o        <= pc_i;
                     pc_set_o    <= pc_set_i;
                     exc_o       <= 1'b0;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               bus_cyc <= 1'b0;
               bus_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_bus.sv
// Directed self-checking bench for mem_stage_bus with hand-computed expected values.
module tb_mem_stage_bus;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        stall_i, stall_o, halt_i, halt_o;
   logic [63:0] ir_i, ir_o;
   logic [31:0] result_i, result_o, reg_data1_i, pc_i, pc_o;
   logic [1:0]  reg_write_i, reg_write_o, fault_o;
   logic        pc_set_i, pc_set_o, exc_i, exc_o;
   logic [31:0] bus_adr;
   logic        bus_cyc, bus_we, bus_ack, bus_err;
   logic [3:0]  bus_sel;
   logic [31:0] bus_out, bus_in;

   int n_tests = 0;
   int n_fail  = 0;
   int starts  = 0;

   mem_stage_bus #(
      .ADDR_W(32), .TIMEOUT_CYC(16), .FAULT_VEC(32'h0000_0040), .ALIGN_VEC(32'h0000_0008)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .stall_o(stall_o),
      .halt_i(halt_i), .halt_o(halt_o), .ir_i(ir_i), .ir_o(ir_o),
      .result_i(result_i), .result_o(result_o), .reg_data1_i(reg_data1_i),
      .reg_write_i(reg_write_i), .reg_write_o(reg_write_o), .pc_i(pc_i), .pc_o(pc_o),
      .pc_set_i(pc_set_i), .pc_set_o(pc_set_o), .exc_i(exc_i), .exc_o(exc_o),
      .fault_o(fault_o), .bus_adr(bus_adr), .bus_cyc(bus_cyc), .bus_we(bus_we),
      .bus_sel(bus_sel), .bus_out(bus_out), .bus_in(bus_in), .bus_ack(bus_ack),
      .bus_err(bus_err)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge bus_cyc) starts++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_op(input logic [3:0] typ, input logic [1:0] sz,
                         input logic [31:0] res, input logic [31:0] d);
      ir_i        = {32'h5A5A_0000, typ, 2'b00, sz, 24'h000000};
      result_i    = res;
      reg_data1_i = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int s0;
      rst_ni = 1'b0; stall_i = 1'b0; halt_i = 1'b0; ir_i = 64'h0; result_i = 32'h0;
      reg_data1_i = 32'h0; reg_write_i = 2'b00; pc_i = 32'h0; pc_set_i = 1'b0; exc_i = 1'b0;
      bus_in = 32'h0; bus_ack = 1'b0; bus_err = 1'b0;
      tick(); tick();
      check("rst_result", result_o, 32'h0);
      check("rst_cyc", bus_cyc, 1'b0);
      check("rst_sel", bus_sel, 4'b0000);
      check("rst_adr", bus_adr, 32'h0);
      check("rst_fault", fault_o, 2'd0);
      check("rst_stall", stall_o, 1'b0);
      rst_ni = 1'b1;
      tick();

      // plain pipe register behaviour and downstream stall hold
      set_op(4'h9, 2'd0, 32'h0000_DEAD, 32'h0);
      pc_i = 32'h100; reg_write_i = 2'b01; halt_i = 1'b1;
      #1 check("pass_stall", stall_o, 1'b0);
      tick();
      check("pass_result", result_o, 32'h0000_DEAD);
      check("pass_pc", pc_o, 32'h100);
      check("pass_halt", halt_o, 1'b1);
      check("pass_ir", ir_o, {32'h5A5A_0000, 32'h9000_0000});
      stall_i = 1'b1; result_i = 32'h0000_BEEF;
      tick();
      check("pass_hold", result_o, 32'h0000_DEAD);
      stall_i = 1'b0; halt_i = 1'b0;

      // load byte at 0x1001
      set_op(4'hc, 2'd2, 32'h1001, 32'h0);
      #1 check("lb_stall_n", stall_o, 1'b1);
      tick();
      check("lb_cyc", bus_cyc, 1'b1);
      check("lb_sel", bus_sel, 4'b0100);
      check("lb_adr", bus_adr, 32'h1001);
      check("lb_we", bus_we, 1'b0);
      check("lb_stall_n1", stall_o, 1'b1);
      bus_in = 32'hAABB_CCDD; bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      check("lb_cyc_drop", bus_cyc, 1'b0);
      check("lb_not_yet", result_o, 32'h0000_DEAD);
      tick();
      check("lb_result", result_o, 32'h0000_00BB);
      check("lb_regw", reg_write_o, 2'b01);
      check("lb_fault", fault_o, 2'd0);
      set_op(4'h9, 2'd0, 32'h0, 32'h0);

      // store half at 0x2002
      set_op(4'hd, 2'd1, 32'h2002, 32'h1234_5678);
      tick();
      check("sh_sel", bus_sel, 4'b0011);
      check("sh_out", bus_out, 32'h5678_5678);
      check("sh_we", bus_we, 1'b1);
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      tick();
      check("sh_result", result_o, 32'h2002);
      set_op(4'h9, 2'd0, 32'h0, 32'h0);

      // load with ack withheld -> timeout
      set_op(4'hc, 2'd0, 32'h4000, 32'h0);
      pc_i = 32'h200;
      tick();
      n = 0;
      while (bus_cyc === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      check("tmo_cycles", n, 16);
      tick();
      check("tmo_exc", exc_o, 1'b1);
      check("tmo_fault", fault_o, 2'd2);
      check("tmo_pc", pc_o, 32'h40);
      check("tmo_pcset", pc_set_o, 1'b1);
      check("tmo_regw", reg_write_o, 2'b00);
      check("tmo_result", result_o, 32'h4000);
      set_op(4'h9, 2'd0, 32'h0, 32'h0);

      // store byte with err and ack together
      set_op(4'hd, 2'd2, 32'h3003, 32'h0000_00FF);
      reg_write_i = 2'b11;
      tick();
      check("err_sel", bus_sel, 4'b0001);
      check("err_out", bus_out, 32'hFFFF_FFFF);
      bus_err = 1'b1; bus_ack = 1'b1;
      tick();
      bus_err = 1'b0; bus_ack = 1'b0;
      tick();
      check("err_fault", fault_o, 2'd1);
      check("err_regw", reg_write_o, 2'b00);
      check("err_exc", exc_o, 1'b1);
      check("err_pc", pc_o, 32'h40);
      set_op(4'h9, 2'd0, 32'h0, 32'h0);
      reg_write_i = 2'b01;

      // ack while downstream stalled
      set_op(4'hc, 2'd1, 32'h5000, 32'h0);
      bus_in = 32'hCAFE_BEEF;
      s0 = starts;
      tick();
      stall_i = 1'b1; bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      check("stl_cyc", bus_cyc, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("stl_hold", result_o, 32'h3003);
         check("stl_stall", stall_o, 1'b1);
         tick();
      end
      stall_i = 1'b0;
      tick();
      check("stl_result", result_o, 32'h0000_CAFE);
      check("stl_exc", exc_o, 1'b0);
      set_op(4'h9, 2'd0, 32'h0, 32'h0);
      tick();
      check("stl_one_cycle", starts - s0, 1);

      // exception vector fetch
      set_op(4'h9, 2'd0, 32'h10, 32'h0);
      exc_i = 1'b1; pc_i = 32'h300;
      #1 check("exc_stall", stall_o, 1'b1);
      tick();
      check("exc_sel", bus_sel, 4'b1111);
      check("exc_we", bus_we, 1'b0);
      bus_in = 32'h0000_1234; bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      tick();
      check("exc_pc", pc_o, 32'h1234);
      check("exc_pcset", pc_set_o, 1'b1);
      exc_i = 1'b0;
      set_op(4'h9, 2'd0, 32'h0, 32'h0);

      // long load at 0x3
      set_op(4'hc, 2'd0, 32'h3, 32'h0);
      tick();
`ifdef MEM_ALIGN_CHECK_EN
      check("mis_nocyc", bus_cyc, 1'b0);
      tick();
      check("mis_fault", fault_o, 2'd3);
      check("mis_pc", pc_o, 32'h8);
      check("mis_exc", exc_o, 1'b1);
`else
      check("mis_sel", bus_sel, 4'b1111);
      check("mis_adr", bus_adr, 32'h3);
      check("mis_cyc", bus_cyc, 1'b1);
      bus_in = 32'h1122_3344; bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      tick();
      check("mis_result", result_o, 32'h1122_3344);
`endif
      set_op(4'h9, 2'd0, 32'h0, 32'h0);
      tick();

      // async reset during a bus cycle
      set_op(4'hc, 2'd0, 32'h6000, 32'h0);
      tick();
      check("ar_cyc_on", bus_cyc, 1'b1);
      rst_ni = 1'b0;
      #1 check("ar_cyc_off", bus_cyc, 1'b0);
      check("ar_result", result_o, 32'h0);
      set_op(4'h9, 2'd0, 32'h0, 32'h0);
      tick();
      rst_ni = 1'b1;
      tick();
      check("ar_idle_cyc", bus_cyc, 1'b0);
      check("ar_idle_stall", stall_o, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
